// File: rtl/gate_event_encoder_pkg.sv
// Shared definitions for the gate event encoder: output FSM encoding,
// slot code width (common with the SPS core) and the arbitration helper.
package gate_event_encoder_pkg;

    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EMIT_ENTRY = 2'd1,
        ST_EMIT_EXIT  = 2'd2,
        ST_GAP        = 2'd3
    } state_e;

    // Fixed-priority pick between pending events: entry always wins over exit.
    function automatic state_e pick_next(input logic entry_pend, input logic exit_pend);
        if (entry_pend) begin
            return ST_EMIT_ENTRY;
        end
        if (exit_pend) begin
            return ST_EMIT_EXIT;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/gate_event_encoder_btn_debounce.sv
// Button front end: 2-FF synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each accepted rising edge.
module gate_event_encoder_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 40000
) (
    input  logic clk,
    input  logic reset_in,
    input  logic raw_in,
    output logic rise
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;

    // Shift the raw level through two flops, then track how long it has differed from the debounced level.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        sync_d   = {sync_q[0], raw_in};
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            // The threshold compare flips the level before the counter could ever pass CNT_MAX.
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    // State register with synchronous reset; debounced level restarts at released.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its neighbours.
        if (reset_in) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/gate_event_encoder.sv
// Gate event encoder top: debounces the entry/exit buttons, keeps one pending
// event per button, captures the exit slot and serialises single-cycle pulses
// separated by a fixed idle gap.
module gate_event_encoder
    import gate_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 40000,
    parameter int GAP_CYCLES      = 4
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              entry_btn_raw,
    input  logic              exit_btn_raw,
    input  logic [SLOT_W-1:0] slot_sw_raw,
    output logic              entry_signal,
    output logic              exit_signal,
    output logic [SLOT_W-1:0] exit_slot,
    output logic              dropped
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    slot_t         slot_sync1_q, slot_sync1_d;
    slot_t         slot_sync2_q, slot_sync2_d;
    logic          entry_rise, exit_rise;
    state_e        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          entry_pend_q, entry_pend_d;
    logic          exit_pend_q, exit_pend_d;
    slot_t         slot_pend_q, slot_pend_d;
    slot_t         exit_slot_q, exit_slot_d;
    logic          dropped_q, dropped_d;
    logic          entry_signal_q, entry_signal_d;
    logic          exit_signal_q, exit_signal_d;
    logic          entry_take, exit_take;

    gate_event_encoder_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_entry_db (
        .clk     (clk),
        .reset_in(reset_in),
        .raw_in  (entry_btn_raw),
        .rise    (entry_rise)
    );

    gate_event_encoder_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exit_db (
        .clk     (clk),
        .reset_in(reset_in),
        .raw_in  (exit_btn_raw),
        .rise    (exit_rise)
    );

    // Next-state logic: arbitrate pending events; the last gap cycle re-arbitrates directly so pulses sit GAP_CYCLES+1 edges apart.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = pick_next(entry_pend_q, exit_pend_q);
            end
            ST_EMIT_ENTRY, ST_EMIT_EXIT: begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = pick_next(entry_pend_q, exit_pend_q);
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: pulses are registered from the state being entered, which also marks the event as taken.
    always_comb begin
        entry_take     = (state_d == ST_EMIT_ENTRY);
        exit_take      = (state_d == ST_EMIT_EXIT);
        entry_signal_d = entry_take;
        exit_signal_d  = exit_take;
    end

    // Event bookkeeping: pending flags, slot capture, exit_slot update and the sticky drop flag.
    always_comb begin
        // A rise in the same cycle its flag is being taken starts a fresh event rather than being dropped.
        entry_pend_d = (entry_pend_q & ~entry_take) | entry_rise;
        exit_pend_d  = (exit_pend_q & ~exit_take) | exit_rise;
        dropped_d    = dropped_q
                     | (entry_rise & entry_pend_q & ~entry_take)
                     | (exit_rise & exit_pend_q & ~exit_take);
        slot_pend_d  = slot_pend_q;
        if (exit_rise && !(exit_pend_q && !exit_take)) begin
            slot_pend_d = slot_sync2_q;
        end
        exit_slot_d  = exit_take ? slot_pend_q : exit_slot_q;
        // Slot bus is synchronised without gray coding: it is settled long before a debounced exit press samples it.
        slot_sync1_d = slot_sw_raw;
        slot_sync2_d = slot_sync1_q;
    end

    // State register: synchronous reset discards in-flight events and returns everything to idle.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q        <= ST_IDLE;
            gap_cnt_q      <= '0;
            entry_pend_q   <= 1'b0;
            exit_pend_q    <= 1'b0;
            slot_pend_q    <= '0;
            exit_slot_q    <= '0;
            dropped_q      <= 1'b0;
            entry_signal_q <= 1'b0;
            exit_signal_q  <= 1'b0;
            slot_sync1_q   <= '0;
            slot_sync2_q   <= '0;
        end else begin
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            entry_pend_q   <= entry_pend_d;
            exit_pend_q    <= exit_pend_d;
            slot_pend_q    <= slot_pend_d;
            exit_slot_q    <= exit_slot_d;
            dropped_q      <= dropped_d;
            entry_signal_q <= entry_signal_d;
            exit_signal_q  <= exit_signal_d;
            slot_sync1_q   <= slot_sync1_d;
            slot_sync2_q   <= slot_sync2_d;
        end
    end

    assign entry_signal = entry_signal_q;
    assign exit_signal  = exit_signal_q;
    assign exit_slot    = exit_slot_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_gate_event_encoder.sv
// Self-checking bench for gate_event_encoder. The main instance uses
// DEBOUNCE_CYCLES=4, GAP_CYCLES=2; a second instance with a long gap keeps an
// entry event pending long enough for a second complete press to be dropped.
module tb_gate_event_encoder;

    localparam int D  = 4;
    localparam int G  = 2;
    localparam int G2 = 20;
    localparam int LAT = D + 3;

    logic       clk           = 1'b0;
    logic       reset_in      = 1'b1;
    logic       entry_btn_raw = 1'b0;
    logic       exit_btn_raw  = 1'b0;
    logic [1:0] slot_sw_raw   = 2'b00;
    logic       entry_signal, exit_signal, dropped;
    logic [1:0] exit_slot;

    logic       entry2_btn_raw = 1'b0;
    logic       exit2_btn_raw  = 1'b0;
    logic       entry2_signal, exit2_signal, dropped2;
    logic [1:0] exit2_slot;

    gate_event_encoder #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .entry_btn_raw(entry_btn_raw),
        .exit_btn_raw (exit_btn_raw),
        .slot_sw_raw  (slot_sw_raw),
        .entry_signal (entry_signal),
        .exit_signal  (exit_signal),
        .exit_slot    (exit_slot),
        .dropped      (dropped)
    );

    gate_event_encoder #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G2)) dut_long_gap (
        .clk          (clk),
        .reset_in     (reset_in),
        .entry_btn_raw(entry2_btn_raw),
        .exit_btn_raw (exit2_btn_raw),
        .slot_sw_raw  (slot_sw_raw),
        .entry_signal (entry2_signal),
        .exit_signal  (exit2_signal),
        .exit_slot    (exit2_slot),
        .dropped      (dropped2)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_exit;
        logic [1:0] slot;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Scoreboard monitor for the main instance: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (entry_signal || exit_signal) begin
            tests_run++;
            if (entry_signal && exit_signal) begin
                tests_failed++;
                $display("FAIL pulse_overlap: both pulses high at edge %0d", cyc);
            end else if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_pulse: entry=%0b exit=%0b at edge %0d, none expected",
                         entry_signal, exit_signal, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.cyc || exit_signal !== mon_e.is_exit ||
                    (mon_e.is_exit && exit_slot !== mon_e.slot)) begin
                    tests_failed++;
                    $display("FAIL pulse_match: got edge=%0d exit=%0b slot=%b, expected edge=%0d exit=%0b slot=%b",
                             cyc, exit_signal, exit_slot, mon_e.cyc, mon_e.is_exit, mon_e.slot);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests_run++;
            tests_failed++;
            mon_e = exp_q.pop_front();
            $display("FAIL missed_pulse: no pulse by edge %0d, expected exit=%0b at edge %0d",
                     cyc, mon_e.is_exit, mon_e.cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input bit ex, input logic [1:0] s);
        exp_t e;
        e.cyc     = c;
        e.is_exit = ex;
        e.slot    = s;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        tick(3);
        reset_in = 1'b0;
        tick(1);
        tests_run++;
        if (entry_signal !== 1'b0) begin tests_failed++; $display("FAIL reset_entry: got %b want 0", entry_signal); end
        tests_run++;
        if (exit_signal !== 1'b0) begin tests_failed++; $display("FAIL reset_exit: got %b want 0", exit_signal); end
        tests_run++;
        if (exit_slot !== 2'b00) begin tests_failed++; $display("FAIL reset_slot: got %b want 00", exit_slot); end
        tests_run++;
        if (dropped !== 1'b0) begin tests_failed++; $display("FAIL reset_dropped: got %b want 0", dropped); end
        tests_run++;
        if (dropped2 !== 1'b0) begin tests_failed++; $display("FAIL reset_dropped2: got %b want 0", dropped2); end
        tick(20);
    endtask

    task automatic test_entry_clean();
        int k;
        k = cyc;
        entry_btn_raw = 1'b1;
        push_exp(k + 1 + LAT, 1'b0, 2'b00);
        tick(10);
        entry_btn_raw = 1'b0;
        tick(15);
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL entry_clean_drain: %0d pulses outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_exit_bounce();
        bit pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int k;
        slot_sw_raw = 2'b10;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            exit_btn_raw = pattern[i];
            tick(1);
        end
        k = cyc;
        exit_btn_raw = 1'b1;
        push_exp(k + 1 + LAT, 1'b1, 2'b10);
        tick(12);
        exit_btn_raw = 1'b0;
        tick(12);
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL exit_bounce_drain: %0d pulses outstanding, want 0", exp_q.size()); end
        tests_run++;
        if (exit_slot !== 2'b10) begin tests_failed++; $display("FAIL exit_bounce_slot_hold: got %b want 10", exit_slot); end
    endtask

    task automatic test_simultaneous();
        int k;
        slot_sw_raw = 2'b01;
        tick(1);
        k = cyc;
        entry_btn_raw = 1'b1;
        exit_btn_raw  = 1'b1;
        push_exp(k + 1 + LAT, 1'b0, 2'b00);
        push_exp(k + 1 + LAT + G + 1, 1'b1, 2'b01);
        tick(LAT + 1);
        // Entry pulse cycle: the previous exit slot must still be presented.
        tests_run++;
        if (exit_slot !== 2'b10) begin tests_failed++; $display("FAIL simul_slot_before_exit: got %b want 10", exit_slot); end
        tick(G + 1);
        for (int i = 0; i <= G; i++) begin
            tests_run++;
            if (exit_slot !== 2'b01) begin tests_failed++; $display("FAIL simul_slot_stable: got %b want 01 at +%0d", exit_slot, i); end
            tick(1);
        end
        entry_btn_raw = 1'b0;
        exit_btn_raw  = 1'b0;
        tick(12);
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL simul_drain: %0d pulses outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_dropped();
        int n_entry = 0;
        int n_exit  = 0;
        int entry_at = -1;
        int exit_at  = -1;
        for (int i = 0; i < 60; i++) begin
            if (entry2_signal) begin n_entry++; entry_at = i; end
            if (exit2_signal) begin n_exit++; exit_at = i; end
            exit2_btn_raw  = (i < 23);
            entry2_btn_raw = (i >= 5 && i < 11) || (i >= 17 && i < 23);
            tick(1);
        end
        tests_run++;
        if (n_entry !== 1) begin tests_failed++; $display("FAIL drop_entry_count: got %0d want 1", n_entry); end
        tests_run++;
        if (n_exit !== 1) begin tests_failed++; $display("FAIL drop_exit_count: got %0d want 1", n_exit); end
        tests_run++;
        if (exit_at !== 8) begin tests_failed++; $display("FAIL drop_exit_time: got %0d want 8", exit_at); end
        tests_run++;
        if (entry_at !== 8 + G2 + 1) begin tests_failed++; $display("FAIL drop_entry_time: got %0d want %0d", entry_at, 8 + G2 + 1); end
        tests_run++;
        if (dropped2 !== 1'b1) begin tests_failed++; $display("FAIL drop_flag_set: got %b want 1", dropped2); end
        tests_run++;
        if (dropped !== 1'b0) begin tests_failed++; $display("FAIL drop_main_clear: got %b want 0", dropped); end
        reset_in = 1'b1;
        tick(2);
        reset_in = 1'b0;
        tick(1);
        tests_run++;
        if (dropped2 !== 1'b0) begin tests_failed++; $display("FAIL drop_flag_reset: got %b want 0", dropped2); end
    endtask

    task automatic test_reset_mid();
        int k;
        k = cyc;
        entry_btn_raw = 1'b1;
        // Reset is sampled at the edge that would have launched the pulse.
        tick(LAT);
        reset_in      = 1'b1;
        entry_btn_raw = 1'b0;
        tick(1);
        tests_run++;
        if (entry_signal !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_entry: got %b want 0", entry_signal); end
        tests_run++;
        if (exit_slot !== 2'b00) begin tests_failed++; $display("FAIL mid_reset_slot: got %b want 00", exit_slot); end
        tick(1);
        reset_in = 1'b0;
        tick(12);
        k = cyc;
        entry_btn_raw = 1'b1;
        push_exp(k + 1 + LAT, 1'b0, 2'b00);
        tick(10);
        entry_btn_raw = 1'b0;
        tick(15);
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL mid_reset_drain: %0d pulses outstanding, want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_entry_clean();
        test_exit_bounce();
        test_simultaneous();
        test_dropped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run always ends even if stimulus stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
